// File: rtl/iob_sfifo_assim.sv
// iob_sfifo_assim: single-clock asymmetric-width FIFO with narrow-unit occupancy tracking
module iob_sfifo_assim #(
   parameter int W_DATA_W   = 32,
   parameter int R_DATA_W   = 8,
   parameter int ADDR_W     = 4,
   parameter int BIG_ENDIAN = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                w_en,
   input  logic [W_DATA_W-1:0] w_data,
   output logic                full,
   output logic                almost_full,
   input  logic                r_en,
   output logic [R_DATA_W-1:0] r_data,
   output logic                r_valid,
   output logic                empty,
   output logic                almost_empty,
   output logic [ADDR_W:0]     level,
   input  logic [ADDR_W:0]     af_thresh,
   input  logic [ADDR_W:0]     ae_thresh,
   output logic                overflow,
   output logic                underflow
);
   localparam int N = W_DATA_W < R_DATA_W ? W_DATA_W : R_DATA_W;
   localparam int W_U = W_DATA_W / N;
   localparam int R_U = R_DATA_W / N;
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] W_STEP = (ADDR_W+1)'(W_U);
   localparam logic [ADDR_W:0] R_STEP = (ADDR_W+1)'(R_U);
   localparam logic [ADDR_W:0] FULL_LIM = (ADDR_W+1)'(DEPTH - W_U);
   logic [N-1:0] mem [DEPTH];
   logic [ADDR_W:0] wptr, rptr;
   logic [R_DATA_W-1:0] rd_word;
   logic w_ok, r_ok;
   assign level = wptr - rptr;
   assign full = level > FULL_LIM;
   assign empty = level < R_STEP;
   assign almost_full = level >= af_thresh;
   assign almost_empty = level <= ae_thresh;
   assign w_ok = w_en & ~full;
   assign r_ok = r_en & ~empty;
   // scatter the accepted wide word into consecutive narrow units in stream order
   always_ff @(posedge clk) begin
      if (w_ok)
         for (int i = 0; i < W_U; i++)
            mem[wptr[ADDR_W-1:0] + ADDR_W'(i)] <= w_data[(BIG_ENDIAN != 0 ? W_U-1-i : i)*N +: N];
   end
   // gather R_U narrow units starting at the read pointer into one read word
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < R_U; i++)
         rd_word[(BIG_ENDIAN != 0 ? R_U-1-i : i)*N +: N] = mem[rptr[ADDR_W-1:0] + ADDR_W'(i)];
   end
   // pointers, registered read port and sticky error flags
   always_ff @(posedge clk) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         r_data <= '0;
         r_valid <= 1'b0;
         overflow <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (w_ok) wptr <= wptr + W_STEP;
         if (r_ok) rptr <= rptr + R_STEP;
         if (r_ok) r_data <= rd_word;
         r_valid <= r_ok;
         if (w_en & full) overflow <= 1'b1;
         if (r_en & empty) underflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_iob_sfifo_assim.sv
// tb_iob_sfifo_assim: directed self-checking bench for iob_sfifo_assim
module tb_iob_sfifo_assim;
   logic clk = 1'b0, rst = 1'b0;
   int checks = 0, errors = 0;
   logic a_w_en = 0, a_r_en = 0, a_full, a_af, a_rv, a_empty, a_ae, a_ov, a_un;
   logic [31:0] a_w_data = 0;
   logic [7:0] a_r_data;
   logic [4:0] a_level, a_af_th = 5'd12, a_ae_th = 5'd4;
   logic b_w_en = 0, b_r_en = 0, b_full, b_af, b_rv, b_empty, b_ae, b_ov, b_un;
   logic [7:0] b_w_data = 0;
   logic [31:0] b_r_data;
   logic [4:0] b_level, b_af_th = 5'd12, b_ae_th = 5'd4;
   logic [31:0] wd;
   always #5 clk = ~clk;
   iob_sfifo_assim #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4), .BIG_ENDIAN(0)) dut_a (
      .clk(clk), .rst(rst), .w_en(a_w_en), .w_data(a_w_data), .full(a_full), .almost_full(a_af),
      .r_en(a_r_en), .r_data(a_r_data), .r_valid(a_rv), .empty(a_empty), .almost_empty(a_ae),
      .level(a_level), .af_thresh(a_af_th), .ae_thresh(a_ae_th), .overflow(a_ov), .underflow(a_un));
   iob_sfifo_assim #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4), .BIG_ENDIAN(1)) dut_b (
      .clk(clk), .rst(rst), .w_en(b_w_en), .w_data(b_w_data), .full(b_full), .almost_full(b_af),
      .r_en(b_r_en), .r_data(b_r_data), .r_valid(b_rv), .empty(b_empty), .almost_empty(b_ae),
      .level(b_level), .af_thresh(b_af_th), .ae_thresh(b_ae_th), .overflow(b_ov), .underflow(b_un));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      tick;
      tick;
      rst = 1;
      chk("rst_level", a_level, 0);
      chk("rst_empty", a_empty, 1);
      chk("rst_full", a_full, 0);
      chk("rst_rvalid", a_rv, 0);
      chk("rst_rdata", a_r_data, 0);
      chk("rst_ovf", a_ov, 0);
      chk("rst_unf", a_un, 0);
      chk("rst_ae", a_ae, 1);
      chk("rst_af", a_af, 0);
      chk("b_rst_empty", b_empty, 1);
      a_af_th = 0;
      #1 chk("af_thresh0", a_af, 1);
      a_af_th = 12;
      // narrow-write / wide-read, big-endian
      b_w_en = 1;
      b_w_data = 8'h11; tick; chk("b_empty1", b_empty, 1);
      b_w_data = 8'h22; tick; chk("b_empty2", b_empty, 1);
      b_w_data = 8'h33; tick; chk("b_empty3", b_empty, 1);
      b_w_data = 8'h44; tick; chk("b_empty4", b_empty, 0);
      chk("b_level4", b_level, 4);
      b_w_en = 0;
      b_r_en = 1; tick; b_r_en = 0;
      chk("b_rdata", b_r_data, 32'h11223344);
      chk("b_rvalid", b_rv, 1);
      chk("b_level0", b_level, 0);
      // wide-write / narrow-read, little-endian
      a_w_en = 1; a_w_data = 32'hDDCCBBAA; tick; a_w_en = 0;
      chk("t1_level", a_level, 4);
      a_r_en = 1;
      tick; chk("t1_rd0", a_r_data, 8'hAA); chk("t1_rv0", a_rv, 1); chk("t1_lv0", a_level, 3);
      tick; chk("t1_rd1", a_r_data, 8'hBB); chk("t1_rv1", a_rv, 1); chk("t1_lv1", a_level, 2);
      tick; chk("t1_rd2", a_r_data, 8'hCC); chk("t1_rv2", a_rv, 1); chk("t1_lv2", a_level, 1);
      tick; chk("t1_rd3", a_r_data, 8'hDD); chk("t1_rv3", a_rv, 1); chk("t1_lv3", a_level, 0);
      a_r_en = 0; tick;
      chk("t1_rv_off", a_rv, 0);
      chk("t1_hold", a_r_data, 8'hDD);
      chk("t1_empty", a_empty, 1);
      chk("t1_unf", a_un, 0);
      // fill to full with threshold tracking
      a_w_en = 1;
      a_w_data = 32'h13121110; tick; chk("f4_ae", a_ae, 1); chk("f4_af", a_af, 0);
      a_w_data = 32'h17161514; tick; chk("f8_ae", a_ae, 0); chk("f8_af", a_af, 0);
      a_w_data = 32'h1B1A1918; tick; chk("f12_ae", a_ae, 0); chk("f12_af", a_af, 1); chk("f12_full", a_full, 0);
      a_w_data = 32'h1F1E1D1C; tick; chk("f16_level", a_level, 16); chk("f16_full", a_full, 1); chk("f16_ovf", a_ov, 0);
      a_w_data = 32'hDEADBEEF; tick; a_w_en = 0;
      chk("ovf_level", a_level, 16);
      chk("ovf_set", a_ov, 1);
      a_r_en = 1;
      tick; chk("fr_rd0", a_r_data, 8'h10); chk("fr_lv15", a_level, 15); chk("fr_full15", a_full, 1);
      tick; chk("fr_rd1", a_r_data, 8'h11);
      tick; chk("fr_rd2", a_r_data, 8'h12);
      tick; chk("fr_rd3", a_r_data, 8'h13); chk("fr_lv12", a_level, 12); chk("fr_full12", a_full, 0);
      chk("ovf_sticky", a_ov, 1);
      a_ae_th = 16;
      #1 chk("ae_thresh16", a_ae, 1);
      a_ae_th = 4;
      for (int i = 0; i < 4; i++) begin
         tick; chk("dr8", a_r_data, 8'h14 + 8'(i));
      end
      chk("dr8_level", a_level, 8);
      // simultaneous write and read
      a_w_en = 1; a_w_data = 32'h23222120; tick; a_w_en = 0;
      chk("sim_level", a_level, 11);
      chk("sim_rd", a_r_data, 8'h18);
      for (int i = 0; i < 7; i++) begin
         tick; chk("drain_a", a_r_data, 8'h19 + 8'(i));
      end
      for (int i = 0; i < 4; i++) begin
         tick; chk("drain_b", a_r_data, 8'h20 + 8'(i));
      end
      chk("drain_empty", a_empty, 1);
      tick; a_r_en = 0;
      chk("unf_set", a_un, 1);
      chk("unf_rv", a_rv, 0);
      chk("unf_level", a_level, 0);
      chk("unf_hold", a_r_data, 8'h23);
      // pointer wrap over many transactions
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < 4; i++) wd[i*8 +: 8] = 8'(k*4 + i) ^ 8'h5A;
         a_w_en = 1; a_w_data = wd; tick; a_w_en = 0;
         a_r_en = 1;
         for (int i = 0; i < 4; i++) begin
            tick; chk("wrap", a_r_data, wd[i*8 +: 8]);
         end
         a_r_en = 0;
      end
      chk("wrap_level", a_level, 0);
      // reset mid-operation
      a_w_en = 1;
      a_w_data = 32'h03020100; tick;
      a_w_data = 32'h07060504; tick;
      a_w_data = 32'h0B0A0908; tick;
      a_w_en = 0;
      chk("pre_rst_level", a_level, 12);
      rst = 0; tick; rst = 1;
      chk("mid_rst_level", a_level, 0);
      chk("mid_rst_empty", a_empty, 1);
      chk("mid_rst_ovf", a_ov, 0);
      chk("mid_rst_unf", a_un, 0);
      chk("mid_rst_rdata", a_r_data, 0);
      a_w_en = 1; a_w_data = 32'hA3A2A1A0; tick; a_w_en = 0;
      a_r_en = 1; tick; a_r_en = 0;
      chk("post_rst_rd", a_r_data, 8'hA0);
      chk("post_rst_level", a_level, 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
